// File: rtl/spi_slave_ram_gen.sv
// SPI slave with on-chip RAM, sampled on clk: frame = cmd bit, 2-bit opcode, DATA_WIDTH payload.
// Latency: opcode executes one cycle after the last payload bit; readout starts on the following edge.
// Backpressure: none; the master owns framing via SS_n. Optional macro SPI_ADDR_AUTOINC_EN.
module spi_slave_ram_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic frame_err
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 2);
    localparam int RX_W  = DATA_WIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK_CMD,
        S_SHIFT,
        S_EXEC,
        S_TX,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    cmd_q, cmd_d;
    logic [RX_W-1:0]         rx_q, rx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    logic [1:0]              opcode;
    logic [DATA_WIDTH-1:0]   payload;
    logic                    exec_err;

    // The received frame is laid out opcode-then-payload once SHIFT completes.
    assign opcode   = rx_q[RX_W-1:DATA_WIDTH];
    assign payload  = rx_q[DATA_WIDTH-1:0];
    // A frame is malformed when the command bit disagrees with opcode[1].
    assign exec_err = (state_q == S_EXEC) && (opcode[1] != cmd_q);

    // Single RAM port: writes use wr_addr, everything else reads through rd_addr.
    assign ram_addr  = (opcode == 2'b01) ? wr_addr_q : rd_addr_q;
    assign mem_rdata = mem[ram_addr];

    // Abort pulses are registered; malformed-frame pulses are flagged during EXEC itself.
    assign frame_err = err_q | exec_err;
    assign MISO      = (state_q == S_TX) & tx_q[DATA_WIDTH-1];

    // Next-state and datapath decode for the frame FSM.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        rx_d      = rx_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!SS_n) state_d = S_CHK_CMD;
            end
            S_CHK_CMD: begin
                if (SS_n) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cmd_d   = MOSI;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (SS_n) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    rx_d  = {rx_q[RX_W-2:0], MOSI};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_WIDTH + 1)) state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                cnt_d = '0;
                if (!exec_err) begin
                    case (opcode)
                        2'b00: wr_addr_d = payload[ADDR_WIDTH-1:0];
                        2'b01: begin
                            mem_we = 1'b1;
`ifdef SPI_ADDR_AUTOINC_EN
                            wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
`endif
                        end
                        2'b10: rd_addr_d = payload[ADDR_WIDTH-1:0];
                        default: begin
                            tx_d = mem_rdata;
`ifdef SPI_ADDR_AUTOINC_EN
                            rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
`endif
                        end
                    endcase
                end
                // SS_n high here still lets the operation land, but skips readout.
                if (SS_n)                                  state_d = S_IDLE;
                else if (!exec_err && opcode == 2'b11)     state_d = S_TX;
                else                                       state_d = S_DONE;
            end
            S_TX: begin
                if (SS_n) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tx_d  = {tx_q[DATA_WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (SS_n) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and datapath registers; reset drops any in-flight frame silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cmd_q     <= 1'b0;
            rx_q      <= '0;
            cnt_q     <= '0;
            tx_q      <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            rx_q      <= rx_d;
            cnt_q     <= cnt_d;
            tx_q      <= tx_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            err_q     <= err_d;
        end
    end

    // RAM array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[ram_addr] <= payload;
    end

endmodule

// File: tb/tb_spi_slave_ram_gen.sv
// Bench for spi_slave_ram_gen: 8-bit default instance plus a 16-bit/4-bit-address instance.
// Frames are driven on negedge; read words are scored against a queue of expected values.
// Checks the autoincrement variant when SPI_ADDR_AUTOINC_EN is defined.
module tb_spi_slave_ram_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ss8 = 1'b1;
    logic ss16 = 1'b1;
    logic mosi = 1'b0;
    logic miso8, fe8, miso16, fe16;

    int checks = 0;
    int errors = 0;
    int errc8 = 0;
    int errc16 = 0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    spi_slave_ram_gen #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .SS_n(ss8), .MOSI(mosi), .MISO(miso8), .frame_err(fe8)
    );

    spi_slave_ram_gen #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut16 (
        .clk(clk), .rst(rst), .SS_n(ss16), .MOSI(mosi), .MISO(miso16), .frame_err(fe16)
    );

    always @(negedge clk) begin
        if (fe8)  errc8  = errc8 + 1;
        if (fe16) errc16 = errc16 + 1;
    end

    typedef struct {
        bit          c;
        logic [1:0]  op;
        logic [15:0] pay;
        logic [15:0] exp_rd;
        int          exp_err;
    } vec_t;

    function automatic vec_t mk(input bit c, input logic [1:0] op, input logic [15:0] pay,
                                input logic [15:0] exp_rd, input int exp_err);
        vec_t v;
        v.c = c; v.op = op; v.pay = pay; v.exp_rd = exp_rd; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic set_ss(input bit sel, input logic v);
        if (sel) ss16 = v;
        else     ss8  = v;
    endtask

    // Stage k at negedge k: 0 idle, 1 cmd, 2-3 opcode, payload, EXEC, then TX bits.
    task automatic frame(input bit sel, input bit c, input logic [1:0] op, input logic [15:0] pay,
                         input int abort_at, input logic [15:0] exp_rd, input int exp_err);
        int w;
        bit tx;
        int last;
        int e0;
        logic [15:0] got;
        logic [15:0] expw;
        w    = sel ? 16 : 8;
        tx   = (op == 2'b11) && c;
        last = tx ? 4 + 2 * w : 4 + w;
        e0   = sel ? errc16 : errc8;
        got  = '0;
        if (tx && abort_at < 0) sb.push_back(exp_rd);
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            if (k >= 5 + w && k <= 4 + 2 * w) got[w - 1 - (k - 5 - w)] = sel ? miso16 : miso8;
            if (k == 4 + w) chk("miso_exec", 32'(sel ? miso16 : miso8), 32'd0);
            if (k == abort_at) begin
                set_ss(sel, 1'b1);
                break;
            end
            if (k == 0) begin
                set_ss(sel, 1'b0);
                mosi = 1'b0;
            end else if (k == 1) mosi = c;
            else if (k <= 3)     mosi = op[3 - k];
            else if (k < 4 + w)  mosi = pay[w - 1 - (k - 4)];
            else                 mosi = 1'b0;
        end
        if (abort_at < 0) begin
            @(negedge clk);
            set_ss(sel, 1'b1);
        end
        @(negedge clk);
        @(negedge clk);
        if (tx && abort_at < 0) begin
            expw = sb.pop_front();
            chk("rd_word", 32'(got), 32'(expw));
        end
        chk("frame_err_cnt", 32'((sel ? errc16 : errc8) - e0), 32'(exp_err));
    endtask

    vec_t tbl[21];
    int   e0;

    initial begin
        tbl[0]  = mk(0, 2'b00, 16'h05, 16'h00, 0);
        tbl[1]  = mk(0, 2'b01, 16'hA5, 16'h00, 0);
        tbl[2]  = mk(1, 2'b10, 16'h05, 16'h00, 0);
        tbl[3]  = mk(1, 2'b11, 16'h00, 16'hA5, 0);
        tbl[4]  = mk(0, 2'b00, 16'h10, 16'h00, 0);
        tbl[5]  = mk(0, 2'b01, 16'h3C, 16'h00, 0);
        tbl[6]  = mk(1, 2'b10, 16'h10, 16'h00, 0);
        tbl[7]  = mk(1, 2'b11, 16'hFF, 16'h3C, 0);
        tbl[8]  = mk(1, 2'b01, 16'h77, 16'h00, 1);
        tbl[9]  = mk(1, 2'b10, 16'h10, 16'h00, 0);
        tbl[10] = mk(1, 2'b11, 16'h00, 16'h3C, 0);
        tbl[11] = mk(0, 2'b11, 16'h00, 16'h00, 1);
        tbl[12] = mk(1, 2'b10, 16'h05, 16'h00, 0);
        tbl[13] = mk(1, 2'b11, 16'h00, 16'hA5, 0);
        tbl[14] = mk(0, 2'b00, 16'hFF, 16'h00, 0);
        tbl[15] = mk(0, 2'b01, 16'h5A, 16'h00, 0);
        tbl[16] = mk(1, 2'b10, 16'hFF, 16'h00, 0);
        tbl[17] = mk(1, 2'b11, 16'h00, 16'h5A, 0);
        tbl[18] = mk(1, 2'b10, 16'hFF, 16'h00, 0);
        tbl[19] = mk(0, 2'b10, 16'h05, 16'h00, 1);
        tbl[20] = mk(1, 2'b11, 16'h00, 16'h5A, 0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_miso8", 32'(miso8), 32'd0);
        chk("rst_fe8", 32'(fe8), 32'd0);
        chk("rst_miso16", 32'(miso16), 32'd0);
        chk("rst_fe16", 32'(fe16), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven frames
        for (int i = 0; i < 21; i++)
            frame(0, tbl[i].c, tbl[i].op, tbl[i].pay, -1, tbl[i].exp_rd, tbl[i].exp_err);

        // Abort mid-payload leaves RAM untouched
        frame(0, 0, 2'b00, 16'h20, -1, 16'h0, 0);
        frame(0, 0, 2'b01, 16'hC3, -1, 16'h0, 0);
        frame(0, 0, 2'b01, 16'hFF, 8, 16'h0, 1);
        frame(0, 1, 2'b10, 16'h20, -1, 16'h0, 0);
        frame(0, 1, 2'b11, 16'h00, -1, 16'hC3, 0);
        // Abort in CHK_CMD and during readout
        frame(0, 1, 2'b11, 16'h00, 1, 16'h0, 1);
        frame(0, 1, 2'b10, 16'h20, -1, 16'h0, 0);
        frame(0, 1, 2'b11, 16'h00, 16, 16'h0, 1);
        frame(0, 1, 2'b10, 16'h20, -1, 16'h0, 0);
        frame(0, 1, 2'b11, 16'h00, -1, 16'hC3, 0);
        // SS_n high during EXEC still completes the address load, no error
        frame(0, 0, 2'b00, 16'h30, 12, 16'h0, 0);
        frame(0, 0, 2'b01, 16'hE7, -1, 16'h0, 0);
        frame(0, 1, 2'b10, 16'h30, -1, 16'h0, 0);
        frame(0, 1, 2'b11, 16'h00, -1, 16'hE7, 0);

        // Reset mid-SHIFT: no frame_err, addresses return to 0
        frame(0, 0, 2'b00, 16'h00, -1, 16'h0, 0);
        frame(0, 0, 2'b01, 16'h99, -1, 16'h0, 0);
        frame(0, 1, 2'b10, 16'h05, -1, 16'h0, 0);
        e0 = errc8;
        @(negedge clk); ss8 = 1'b0; mosi = 1'b0;
        @(negedge clk); mosi = 1'b1;
        @(negedge clk); mosi = 1'b1;
        @(negedge clk); mosi = 1'b1;
        @(negedge clk); mosi = 1'b1;
        @(negedge clk); mosi = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("midrst_miso", 32'(miso8), 32'd0);
        chk("midrst_fe", 32'(fe8), 32'd0);
        rst = 1'b0;
        ss8 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_err_cnt", 32'(errc8 - e0), 32'd0);
        frame(0, 1, 2'b11, 16'h00, -1, 16'h99, 0);
        frame(0, 0, 2'b01, 16'h66, -1, 16'h0, 0);
        frame(0, 1, 2'b10, 16'h00, -1, 16'h0, 0);
        frame(0, 1, 2'b11, 16'h00, -1, 16'h66, 0);

        // Consecutive writes/reads from the top address
        frame(0, 0, 2'b00, 16'hFF, -1, 16'h0, 0);
        frame(0, 0, 2'b01, 16'h11, -1, 16'h0, 0);
        frame(0, 0, 2'b01, 16'h22, -1, 16'h0, 0);
        frame(0, 1, 2'b10, 16'hFF, -1, 16'h0, 0);
`ifdef SPI_ADDR_AUTOINC_EN
        frame(0, 1, 2'b11, 16'h00, -1, 16'h11, 0);
        frame(0, 1, 2'b11, 16'h00, -1, 16'h22, 0);
`else
        frame(0, 1, 2'b11, 16'h00, -1, 16'h22, 0);
        frame(0, 1, 2'b11, 16'h00, -1, 16'h22, 0);
`endif

        // Wide instance: 16-bit word at top of 4-bit address space
        frame(1, 0, 2'b00, 16'h000F, -1, 16'h0, 0);
        frame(1, 0, 2'b01, 16'hBEEF, -1, 16'h0, 0);
        frame(1, 1, 2'b10, 16'h000F, -1, 16'h0, 0);
        frame(1, 1, 2'b11, 16'h0000, -1, 16'hBEEF, 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_ram_gen.md
Name: spi_slave_ram_gen

Overview:
Parametrised next-generation SPI slave with on-chip single-port RAM, sampled directly on the system clock with no separate SCLK. A frame carries one command bit, a 2-bit opcode and a DATA_WIDTH payload. Over a frame the master can load a write address, write data, load a read address, or read data back on MISO. Compared with the fixed 8-bit version, it adds width/depth parameters, a frame-error flag for aborted or malformed frames, and optional address auto-increment.

Parameters:
DATA_WIDTH, 8, payload width and RAM word width.
ADDR_WIDTH, 8, RAM address width; must be <= DATA_WIDTH; depth = 2**ADDR_WIDTH.

Ports:
clk  input  1  system clock; all sampling on rising edge.
rst  input  1  asynchronous active-high reset.
SS_n  input  1  slave select, active low.
MOSI  input  1  serial data in, MSB first.
MISO  output  1  serial data out, MSB first.
frame_err  output  1  one-cycle pulse on an aborted or malformed frame.

Behaviour:
- Frame: 1 command bit c, then opcode[1:0], then payload[DATA_WIDTH-1:0]; total DATA_WIDTH+3 bits, one bit per clk.
- FSM states:
  - IDLE: SS_n sampled low -> CHK_CMD.
  - CHK_CMD: samples c -> SHIFT.
  - SHIFT: counts DATA_WIDTH+2 bits into rx shift register -> EXEC.
  - EXEC: one cycle; decodes the frame -> TX if opcode 11, else DONE.
  - TX: DATA_WIDTH cycles -> DONE.
  - DONE: waits for SS_n high -> IDLE.
- SS_n sampled high in any state -> IDLE on the next edge.
- EXEC decoding:
  - opcode[1] != c -> frame_err pulses this cycle; no state change.
  - 00 -> wr_addr <= payload[ADDR_WIDTH-1:0].
  - 01 -> mem[wr_addr] <= payload.
  - 10 -> rd_addr <= payload[ADDR_WIDTH-1:0].
  - 11 -> tx_reg <= mem[rd_addr]; payload ignored (dummy).
- Opcode 11 readout: MISO = tx_reg MSB at the first TX edge, then the next bit on each clk; DATA_WIDTH bits total. MISO = 0 in all other states.
- Abort: SS_n high during CHK_CMD, SHIFT or TX:
  - frame_err pulses the next cycle; FSM -> IDLE.
  - Abort in SHIFT: no address or RAM update.
  - Abort in TX: rest of the word is discarded.
  - SS_n high in EXEC: the EXEC operation completes, then IDLE.
- Reset: FSM=IDLE, MISO=0, frame_err=0, wr_addr=0, rd_addr=0, shift registers and counters=0. RAM contents are not reset. Reset mid-frame drops the frame and raises no frame_err.
- Opcode 11 with no prior opcode 10 reads from rd_addr (0 after reset).
- Back-to-back frames need at least one cycle with SS_n high between them.

Optional Feature:
SPI_ADDR_AUTOINC_EN:
- Defined: after each opcode 01 EXEC, wr_addr increments; after each opcode 11 EXEC, rd_addr increments. Both wrap 2**ADDR_WIDTH-1 -> 0. Aborted or errored frames do not increment.
- Undefined: addresses change only via opcodes 00 and 10.

Test Plan:
(Default parameters; SS_n and MOSI driven on negedge.)
- Write/read: frame 0,00,0x05; frame 0,01,0xA5; frame 1,10,0x05; frame 1,11,0x00 -> MISO = 1,0,1,0,0,1,0,1 on the 8 TX cycles; frame_err stays 0.
- Abort: frame 0,01,0xFF with SS_n raised after 4 payload bits -> frame_err pulses once; re-read of mem[wr_addr] returns the prior value.
- Malformed: c=1 with opcode 01 -> frame_err pulses in EXEC; RAM and addresses unchanged.
- Reset: rst=1 mid-SHIFT -> MISO=0, FSM IDLE, frame_err=0; next read frame uses rd_addr=0.
- Autoinc (macro defined): wr_addr=0xFF; write 0x11, then write 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22. Two reads from rd_addr=0xFF return 0x11 then 0x22.
- Parameter sweep: DATA_WIDTH=16, ADDR_WIDTH=4; write 0xBEEF to addr 0xF, read back -> MISO serialises 0xBEEF MSB first over 16 cycles.
